pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 40 ++++
 rtl/pc_sequencer.sv | 98 +++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control bundle between the sequencer and its surrounding
// pipeline/testbench.
//   slave  (sequencer side): takes start/halt/mem_wait and the EXECUTE-stage
//          redirect requests; drives pc, stage enables, mepc write request
//          and the retired counter.
//   master (driver side):    the mirror image.
interface pc_sequencer_if;
    logic        start;
    logic        halt;
    logic        mem_wait;
    logic        is_jump;
    logic [31:0] jump_target;
    logic        is_trap;
    logic [31:0] mtvec;
    logic        is_mret;
    logic [31:0] mepc;
    logic [31:0] pc;
    logic        fetch_en;
    logic        decode_en;
    logic        exec_en;
    logic        mem_en;
    logic        wb_en;
    logic        mepc_wr;
    logic [31:0] mepc_val;
    logic [31:0] retired;

    modport slave (
        input  start, halt, mem_wait, is_jump, jump_target,
               is_trap, mtvec, is_mret, mepc,
        output pc, fetch_en, decode_en, exec_en, mem_en, wb_en,
               mepc_wr, mepc_val, retired
    );

    modport master (
        output start, halt, mem_wait, is_jump, jump_target,
               is_trap, mtvec, is_mret, mepc,
        input  pc, fetch_en, decode_en, exec_en, mem_en, wb_en,
               mepc_wr, mepc_val, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer. Walks each instruction
// through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, raising one stage enable
// per state, and owns the program counter (word address, modulo IMEM_DEPTH).
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset
//   bus  - pc_sequencer_if.slave: start/halt/mem_wait, redirect requests
//          (jump, trap, mret) sampled in EXECUTE, and outputs pc, stage
//          enables, mepc write request/value and retired count.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          IMEM_DEPTH = 64
) (
    input  logic           clk,
    input  logic           rstn,
    pc_sequencer_if.slave  bus
);

    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_npc;      // next pc chosen in EXECUTE, applied at WRITEBACK exit
    logic [31:0] r_retired;
    logic        r_mepc_wr;
    logic [31:0] r_mepc_val;
    logic [31:0] w_npc;

    // Non-trap redirect choice; trap is handled separately because it
    // bypasses MEMORY/WRITEBACK entirely.
    always_comb begin
        w_npc = (r_pc + 32'd1) & PC_MASK;
        if (bus.is_mret)
            w_npc = bus.mepc & PC_MASK;
        else if (bus.is_jump)
            w_npc = bus.jump_target & PC_MASK;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC & PC_MASK;
            r_npc      <= 32'd0;
            r_retired  <= 32'd0;
            r_mepc_wr  <= 1'b0;
            r_mepc_val <= 32'd0;
        end else begin
            r_mepc_wr <= 1'b0;
            case (r_state)
                S_IDLE:
                    if (bus.start && !bus.halt)
                        r_state <= S_FETCH;
                S_FETCH:
                    r_state <= S_DECODE;
                S_DECODE:
                    r_state <= S_EXECUTE;
                S_EXECUTE:
                    if (bus.is_trap) begin
                        r_state    <= bus.halt ? S_IDLE : S_FETCH;
                        r_pc       <= bus.mtvec & PC_MASK;
                        r_mepc_wr  <= 1'b1;
                        r_mepc_val <= r_pc;
                    end else begin
                        r_state <= S_MEMORY;
                        r_npc   <= w_npc;
                    end
                S_MEMORY:
                    if (!bus.mem_wait)
                        r_state <= S_WRITEBACK;
                S_WRITEBACK: begin
                    r_state   <= bus.halt ? S_IDLE : S_FETCH;
                    r_pc      <= r_npc;
                    r_retired <= r_retired + 32'd1;
                end
                default:
                    r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pc        = r_pc;
    assign bus.fetch_en  = (r_state == S_FETCH);
    assign bus.decode_en = (r_state == S_DECODE);
    assign bus.exec_en   = (r_state == S_EXECUTE);
    assign bus.mem_en    = (r_state == S_MEMORY);
    assign bus.wb_en     = (r_state == S_WRITEBACK);
    assign bus.mepc_wr   = r_mepc_wr;
    assign bus.mepc_val  = r_mepc_val;
    assign bus.retired   = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_fail;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(32'd0), .IMEM_DEPTH(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] en();
        return {27'd0, bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH, advance to EXECUTE.
    task automatic to_exec();
        step();
        step();
    endtask

    // From EXECUTE (non-trap, mem_wait=0), advance through MEM, WB to next FETCH.
    task automatic fin();
        step();
        step();
        step();
    endtask

    initial begin
        logic [31:0] seq_en [5];
        n_chk  = 0;
        n_fail = 0;
        seq_en[0] = 32'h10; seq_en[1] = 32'h08; seq_en[2] = 32'h04;
        seq_en[3] = 32'h02; seq_en[4] = 32'h01;

        rstn = 1'b0;
        bus.start = 0; bus.halt = 0; bus.mem_wait = 0;
        bus.is_jump = 0; bus.jump_target = 0;
        bus.is_trap = 0; bus.mtvec = 0;
        bus.is_mret = 0; bus.mepc = 0;
        #12;
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_en", en(), 32'd0);
        chk("rst_ret", bus.retired, 32'd0);
        chk("rst_mepc", {bus.mepc_val[30:0], bus.mepc_wr}, 32'd0);
        rstn = 1'b1;
        step();
        step();
        chk("idle_hold", en(), 32'd0);

        // Sequential execution, three instructions.
        bus.start = 1;
        step();
        bus.start = 0;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 5; s++) begin
                chk($sformatf("seq_en_%0d_%0d", i, s), en(), seq_en[s]);
                chk($sformatf("seq_pc_%0d_%0d", i, s), bus.pc, 32'(i));
                step();
            end
        end
        chk("seq_ret3", bus.retired, 32'd3);
        chk("seq_pc3", bus.pc, 32'd3);
        for (int i = 3; i < 9; i++)
            for (int s = 0; s < 5; s++) step();
        chk("seq_pc9", bus.pc, 32'd9);

        // Jump from pc 9 to 0x1E.
        to_exec();
        bus.is_jump = 1; bus.jump_target = 32'h1E;
        step();
        bus.is_jump = 0;
        step();
        step();
        chk("jmp_pc", bus.pc, 32'd30);
        chk("jmp_ret", bus.retired, 32'd10);

        // Jump back to 8 to set up the trap.
        to_exec();
        bus.is_jump = 1; bus.jump_target = 32'd8;
        step();
        bus.is_jump = 0;
        step();
        step();
        chk("jmp8_pc", bus.pc, 32'd8);

        // Trap at pc 8 to mtvec 47.
        to_exec();
        bus.is_trap = 1; bus.mtvec = 32'd47;
        step();
        bus.is_trap = 0;
        chk("trap_en", en(), 32'h10);
        chk("trap_pc", bus.pc, 32'd47);
        chk("trap_mwr", {31'd0, bus.mepc_wr}, 32'd1);
        chk("trap_mval", bus.mepc_val, 32'd8);
        chk("trap_ret", bus.retired, 32'd11);
        step();
        chk("trap_mwr_off", {31'd0, bus.mepc_wr}, 32'd0);
        chk("trap_mval_hold", bus.mepc_val, 32'd8);
        step();
        bus.is_mret = 1; bus.mepc = 32'd9;
        step();
        bus.is_mret = 0;
        step();
        step();
        chk("mret_pc", bus.pc, 32'd9);
        chk("mret_ret", bus.retired, 32'd12);

        // All redirects at once: trap wins.
        to_exec();
        bus.is_trap = 1; bus.is_jump = 1; bus.is_mret = 1;
        bus.mtvec = 32'd20; bus.mepc = 32'd5; bus.jump_target = 32'd3;
        step();
        bus.is_trap = 0; bus.is_jump = 0; bus.is_mret = 0;
        chk("prio_pc", bus.pc, 32'd20);
        chk("prio_ret", bus.retired, 32'd12);

        // Jump to 63, then sequential wrap to 0 with ignored jump outside EXECUTE.
        to_exec();
        bus.is_jump = 1; bus.jump_target = 32'd63;
        step();
        bus.is_jump = 0;
        step();
        step();
        chk("pc63", bus.pc, 32'd63);
        to_exec();
        step();
        bus.is_jump = 1; bus.jump_target = 32'd40;
        step();
        step();
        bus.is_jump = 0;
        chk("wrap_pc", bus.pc, 32'd0);
        chk("wrap_ret", bus.retired, 32'd14);

        // Out-of-range jump target is masked: 70 -> 6.
        to_exec();
        bus.is_jump = 1; bus.jump_target = 32'd70;
        step();
        bus.is_jump = 0;
        step();
        step();
        chk("mask_pc", bus.pc, 32'd6);

        // mem_wait high for three MEMORY cycles.
        to_exec();
        bus.mem_wait = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.mem_wait = 0;
            chk($sformatf("wait_mem_%0d", k), en(), 32'h02);
            step();
        end
        chk("wait_wb", en(), 32'h01);
        step();
        chk("wait_pc", bus.pc, 32'd7);
        chk("wait_ret", bus.retired, 32'd16);

        // Asynchronous reset in the middle of a MEMORY wait.
        to_exec();
        bus.mem_wait = 1;
        step();
        step();
        chk("pre_rst_mem", en(), 32'h02);
        rstn = 1'b0;
        #1;
        chk("arst_en", en(), 32'd0);
        chk("arst_pc", bus.pc, 32'd0);
        chk("arst_ret", bus.retired, 32'd0);
        chk("arst_mval", bus.mepc_val, 32'd0);
        bus.mem_wait = 0;
        step();
        rstn = 1'b1;
        step();
        step();
        chk("post_rst_idle", en(), 32'd0);

        // halt in IDLE blocks start.
        bus.halt = 1; bus.start = 1;
        step();
        step();
        chk("halt_idle", en(), 32'd0);
        bus.halt = 0;
        step();
        bus.start = 0;
        chk("restart", en(), 32'h10);

        // halt during WRITEBACK returns to IDLE with pc advanced.
        to_exec();
        step();
        step();
        chk("h_wb", en(), 32'h01);
        bus.halt = 1;
        step();
        bus.halt = 0;
        chk("h_idle_en", en(), 32'd0);
        chk("h_pc", bus.pc, 32'd1);
        chk("h_ret", bus.retired, 32'd1);
        step();
        step();
        chk("h_stay", en(), 32'd0);
        chk("h_pc_hold", bus.pc, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
